seg_scan: RTL

Multiplexed 8-digit seven-segment display driver consuming the packed 32-bit BCD/hex word produced by the digital clock core. It latches the word, scans one digit per scan period, and decodes each nibble to segment patterns. Digit and segment outputs go straight to board pins. New words are applied only at frame boundaries, so the display never tears.

---
 rtl/seg_pkg.sv | 17 +
 rtl/seg_decode.sv | 11 +
 rtl/seg_scan.sv | 104 ++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan driver: glyph table, digit count
// and the scan divider terminal count.
package seg_pkg;

  localparam int DIG_NUM = 8;

  // Active-high {g,f,e,d,c,b,a} patterns, entry 0 in the low slot.
  localparam logic [15:0][6:0] GLYPH_TAB = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  function automatic int calc_cnt_max(input int clk_freq, input int scan_hz);
    return clk_freq / scan_hz - 1;
  endfunction

endpackage

// File: rtl/seg_decode.sv
// Nibble to active-high seven-segment pattern (0-9 plus hex A,b,C,d,E,F).
module seg_decode
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] glyph
);

  assign glyph = GLYPH_TAB[nibble];

endmodule

// File: rtl/seg_scan.sv
// Multiplexed 8-digit seven-segment driver with frame-aligned word updates.
// Optional decimal points are enabled by defining SEG_DP_EN.
module seg_scan
  import seg_pkg::*;
#(
  parameter int CLK_FREQ    = 50_000_000,
  parameter int SCAN_HZ     = 1000,
  parameter bit SEG_ACT_LOW = 1'b1,
  parameter bit SEL_ACT_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] din,
  input  logic        din_vld,
`ifdef SEG_DP_EN
  input  logic [7:0]  dp,
`endif
  output logic [7:0]  sel,
  output logic [6:0]  seg,
  output logic        seg_dp,
  output logic        frame_done
);

  localparam int CNT_MAX = calc_cnt_max(CLK_FREQ, SCAN_HZ);
  localparam int CNT_W   = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);

  localparam logic [6:0] SEG_OFF = SEG_ACT_LOW ? 7'h7F : 7'h00;
  localparam logic [7:0] SEL_OFF = SEL_ACT_LOW ? 8'hFF : 8'h00;
  localparam logic       DP_OFF  = SEG_ACT_LOW;

  logic [CNT_W-1:0] cnt;
  logic [2:0]       idx;
  logic             started;
  logic             wrap_q;
  logic [31:0]      pending;
  logic [31:0]      shadow;
  logic             tick;
  logic             wrap;
  logic [3:0]       nibble;
  logic [6:0]       glyph;
  logic             dp_bit;

  assign tick   = (cnt == CNT_W'(CNT_MAX));
  assign wrap   = tick && (idx == 3'(DIG_NUM - 1));
  // shadow and idx update on the same edge, so the mux always sees the new word
  assign nibble = shadow[{idx, 2'b00} +: 4];

`ifdef SEG_DP_EN
  logic [7:0] pending_dp;
  logic [7:0] shadow_dp;

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_dp <= '0;
      shadow_dp  <= '0;
    end else begin
      if (din_vld) pending_dp <= dp;
      if (wrap)    shadow_dp  <= pending_dp;
    end
  end

  assign dp_bit = shadow_dp[idx];
`else
  assign dp_bit = 1'b0;
`endif

  seg_decode u_decode (
    .nibble (nibble),
    .glyph  (glyph)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      idx        <= 3'(DIG_NUM - 1);
      started    <= 1'b0;
      wrap_q     <= 1'b0;
      pending    <= '0;
      shadow     <= '0;
      sel        <= SEL_OFF;
      seg        <= SEG_OFF;
      seg_dp     <= DP_OFF;
      frame_done <= 1'b0;
    end else begin
      cnt <= tick ? '0 : cnt + 1'b1;
      if (din_vld) pending <= din;
      if (tick) begin
        idx     <= idx + 3'd1;
        started <= 1'b1;
      end
      // NOTE: non-blocking, so shadow captures pending as it was before any same-cycle din_vld write.
      if (wrap) shadow <= pending;
      // The power-up wrap only aligns the scan; it does not end a real frame.
      wrap_q     <= wrap && started;
      frame_done <= wrap_q;
      if (started) begin
        sel    <= SEL_OFF ^ (8'd1 << idx);
        seg    <= SEG_OFF ^ glyph;
        seg_dp <= DP_OFF ^ dp_bit;
      end
    end
  end

endmodule
